// File: rtl/vram_scanout_if.sv
// -----------------------------------------------------------------------------
// vram_scanout_if
// Read bus between the scanout fetcher and the video memory.
//   vram_addr   : word address of the pixel being read (fetcher -> memory)
//   vram_rd_en  : read strobe qualifying vram_addr      (fetcher -> memory)
//   vram_data   : pixel word, RD_LAT clocks after addr  (memory  -> fetcher)
// master = fetcher side, slave = memory side.
// -----------------------------------------------------------------------------
interface vram_scanout_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 12
);
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_rd_en;
  logic [DATA_W-1:0] vram_data;

  modport master (output vram_addr, output vram_rd_en, input  vram_data);
  modport slave  (input  vram_addr, input  vram_rd_en, output vram_data);
endinterface

// File: rtl/vram_scanout.sv
// -----------------------------------------------------------------------------
// vram_scanout
// Turns the VGA timing position (row, col) into framebuffer read addresses and
// returns the colour for that position exactly RD_LAT clocks after the sample.
// Handles 1x/2x pixel scaling, wrap-around X/Y scroll and a border colour for
// visible pixels outside the framebuffer.
//
// Ports
//   clk, rst      : pixel clock, synchronous active-high reset
//   row, col      : current timing position
//   mode          : 0 = 1x, 1 = 2x scale (shadowed at the frame boundary)
//   scroll_x/y    : scroll offsets, < FB_W / FB_H (shadowed at frame boundary)
//   border_color  : colour for visible pixels outside the framebuffer
//   vram          : memory read bus (master side)
//   vga_data      : registered output pixel
//   pix_valid     : vga_data is a visible pixel
// -----------------------------------------------------------------------------
module vram_scanout #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int FB_W      = 320,
  parameter int FB_H      = 240,
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic              mode,
  input  logic [COL_W-1:0]  scroll_x,
  input  logic [ROW_W-1:0]  scroll_y,
  input  logic [DATA_W-1:0] border_color,
  vram_scanout_if.master    vram,
  output logic [DATA_W-1:0] vga_data,
  output logic              pix_valid
);

  localparam int CW1 = COL_W + 1;
  localparam int RW1 = ROW_W + 1;

  // One extra bit so the constants fit and scroll sums cannot overflow.
  localparam logic [COL_W:0] HACT = CW1'(H_ACTIVE);
  localparam logic [ROW_W:0] VACT = RW1'(V_ACTIVE);
  localparam logic [COL_W:0] FBW  = CW1'(FB_W);
  localparam logic [ROW_W:0] FBH  = RW1'(FB_H);

  typedef enum logic [1:0] {CLS_BLANK, CLS_BORDER, CLS_FETCH} cls_e;

  // Frame-boundary shadows
  logic              r_mode;
  logic [COL_W-1:0]  r_scroll_x;
  logic [ROW_W-1:0]  r_scroll_y;

  logic [ADDR_W-1:0] r_vram_addr;
  logic              r_vram_rd_en;
  logic [DATA_W-1:0] r_vga_data;
  logic              r_pix_valid;

  // Class and border colour travel alongside the memory read.
  cls_e              r_cls_pipe [RD_LAT];
  logic [DATA_W-1:0] r_bc_pipe  [RD_LAT];

  logic              w_frame;
  logic              w_blank;
  logic              w_out_fb;
  cls_e              w_cls;
  logic [COL_W-1:0]  w_cx;
  logic [ROW_W-1:0]  w_ry;
  logic [COL_W:0]    w_sum_x;
  logic [ROW_W:0]    w_sum_y;
  logic [COL_W:0]    w_fx;
  logic [ROW_W:0]    w_fy;
  logic [ADDR_W-1:0] w_addr;

  assign w_frame  = ({1'b0, row} == VACT) && (col == '0);

  assign w_cx     = r_mode ? (col >> 1) : col;
  assign w_ry     = r_mode ? (row >> 1) : row;

  assign w_blank  = ({1'b0, col} >= HACT) || ({1'b0, row} >= VACT);
  assign w_out_fb = ({1'b0, w_cx} >= FBW) || ({1'b0, w_ry} >= FBH);

  always_comb begin
    w_cls = CLS_FETCH;
    if (w_blank)       w_cls = CLS_BLANK;
    else if (w_out_fb) w_cls = CLS_BORDER;
  end

  // Both operands are < FB_W (resp. FB_H) for a fetch, so one subtract wraps.
  assign w_sum_x = {1'b0, w_cx} + {1'b0, r_scroll_x};
  assign w_sum_y = {1'b0, w_ry} + {1'b0, r_scroll_y};
  assign w_fx    = (w_sum_x >= FBW) ? (w_sum_x - FBW) : w_sum_x;
  assign w_fy    = (w_sum_y >= FBH) ? (w_sum_y - FBH) : w_sum_y;

  // Arithmetic done modulo 2^ADDR_W, which is the required truncation.
  assign w_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(w_fy) * ADDR_W'(FB_W)
                 + ADDR_W'(w_fx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= 1'b0;
      r_scroll_x   <= '0;
      r_scroll_y   <= '0;
      r_vram_addr  <= '0;
      r_vram_rd_en <= 1'b0;
      r_vga_data   <= '0;
      r_pix_valid  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_cls_pipe[i] <= CLS_BLANK;
        r_bc_pipe[i]  <= '0;
      end
    end else begin
      if (w_frame) begin
        r_mode     <= mode;
        r_scroll_x <= scroll_x;
        r_scroll_y <= scroll_y;
      end

      // Address holds when not fetching; only rd_en qualifies it.
      r_vram_rd_en <= (w_cls == CLS_FETCH);
      if (w_cls == CLS_FETCH) r_vram_addr <= w_addr;

      r_cls_pipe[0] <= w_cls;
      r_bc_pipe[0]  <= border_color;
      for (int i = 1; i < RD_LAT; i++) begin
        r_cls_pipe[i] <= r_cls_pipe[i-1];
        r_bc_pipe[i]  <= r_bc_pipe[i-1];
      end

      case (r_cls_pipe[RD_LAT-1])
        CLS_FETCH: begin
          r_vga_data  <= vram.vram_data;
          r_pix_valid <= 1'b1;
        end
        CLS_BORDER: begin
          r_vga_data  <= r_bc_pipe[RD_LAT-1];
          r_pix_valid <= 1'b1;
        end
        default: begin
          r_vga_data  <= '0;
          r_pix_valid <= 1'b0;
        end
      endcase
    end
  end

  assign vram.vram_addr  = r_vram_addr;
  assign vram.vram_rd_en = r_vram_rd_en;
  assign vga_data        = r_vga_data;
  assign pix_valid       = r_pix_valid;

endmodule

// File: tb/tb_vram_scanout.sv
// -----------------------------------------------------------------------------
// tb_vram_scanout
// Two fetchers (RD_LAT=1 and RD_LAT=3) share one stimulus stream. Each has a
// memory model returning a hash of the address RD_LAT clocks after the
// address is issued. A frame-level reference model (plain modular arithmetic
// and per-latency queues of expected pixels) predicts every output each clock.
// -----------------------------------------------------------------------------
module tb_vram_scanout;

  localparam int AW = 18;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [8:0]    row;
  logic [9:0]    col;
  logic          mode;
  logic [9:0]    scroll_x;
  logic [8:0]    scroll_y;
  logic [DW-1:0] border_color;
  logic [DW-1:0] vga1, vga3;
  logic          pv1, pv3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vram_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) vif1 ();
  vram_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) vif3 ();

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[11:0] ^ {a[17:12], a[17:12]} ^ 12'h5A3;
  endfunction

  // Latency-1 memory: data for the address on the bus is seen at the next edge.
  assign vif1.vram_data = mem_word(vif1.vram_addr);

  // Latency-3 memory: two extra address stages.
  logic [AW-1:0] a3_d1, a3_d2;
  always @(posedge clk) begin
    a3_d1 <= vif3.vram_addr;
    a3_d2 <= a3_d1;
  end
  assign vif3.vram_data = mem_word(a3_d2);

  vram_scanout #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .row(row), .col(col), .mode(mode),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .border_color(border_color),
    .vram(vif1), .vga_data(vga1), .pix_valid(pv1)
  );

  vram_scanout #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .row(row), .col(col), .mode(mode),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .border_color(border_color),
    .vram(vif3), .vga_data(vga3), .pix_valid(pv3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int              sh_mode, sh_sx, sh_sy;
  logic [AW-1:0]   e_addr;
  logic            e_rden;
  logic [DW:0]     e_o1, e_o3;       // {valid, data}
  logic [DW:0]     q1[$], q3[$];

  task automatic model();
    int r, c, cx, ry, fx, fy, a;
    logic [DW:0] res;
    r = int'(row);
    c = int'(col);
    if (rst) begin
      sh_mode = 0; sh_sx = 0; sh_sy = 0;
      e_addr = '0; e_rden = 1'b0; e_o1 = '0; e_o3 = '0;
      q1 = '{13'h0};
      q3 = '{13'h0, 13'h0, 13'h0};
      return;
    end
    cx = sh_mode ? c / 2 : c;
    ry = sh_mode ? r / 2 : r;
    e_rden = 1'b0;
    if (c >= 640 || r >= 480) begin
      res = '0;
    end else if (cx >= 320 || ry >= 240) begin
      res = {1'b1, border_color};
    end else begin
      fx = (cx + sh_sx) % 320;
      fy = (ry + sh_sy) % 240;
      a  = (fy * 320 + fx) % (1 << AW);
      e_addr = a[AW-1:0];
      e_rden = 1'b1;
      res = {1'b1, mem_word(e_addr)};
    end
    e_o1 = q1.pop_front(); q1.push_back(res);
    e_o3 = q3.pop_front(); q3.push_back(res);
    if (r == 480 && c == 0) begin
      sh_mode = int'(mode); sh_sx = int'(scroll_x); sh_sy = int'(scroll_y);
    end
  endtask

  // One clock: drive on the falling edge, model at the rising edge, check 1ns later.
  task automatic cyc(input logic r, input int rw, input int cl);
    logic [8:0] rr;
    logic [9:0] cc;
    rr = rw[8:0];
    cc = cl[9:0];
    @(negedge clk);
    rst = r; row = rr; col = cc;
    @(posedge clk);
    model();
    #1;
    chk("addr1", 32'(vif1.vram_addr), 32'(e_addr));
    chk("rden1", 32'(vif1.vram_rd_en), 32'(e_rden));
    chk("out1",  32'({pv1, vga1}), 32'(e_o1));
    chk("addr3", 32'(vif3.vram_addr), 32'(e_addr));
    chk("rden3", 32'(vif3.vram_rd_en), 32'(e_rden));
    chk("out3",  32'({pv3, vga3}), 32'(e_o3));
  endtask

  task automatic frame(input logic md, input int sx, input int sy);
    mode = md; scroll_x = sx[9:0]; scroll_y = sy[8:0];
    cyc(1'b0, 480, 0);
  endtask

  initial begin
    int r, c;
    rst = 1'b1; row = '0; col = '0; mode = 1'b0;
    scroll_x = '0; scroll_y = '0; border_color = '0;
    q1 = '{13'h0};
    q3 = '{13'h0, 13'h0, 13'h0};

    // Reset state
    cyc(1'b1, 0, 0);
    cyc(1'b1, 0, 0);
    chk("rst_addr", 32'(vif1.vram_addr), 32'd0);
    chk("rst_pv",   32'(pv1), 32'd0);

    // 1x, no scroll: (2,5) -> 645
    cyc(1'b0, 2, 5);
    chk("a645",   32'(vif1.vram_addr), 32'd645);
    chk("rd645",  32'(vif1.vram_rd_en), 32'd1);
    cyc(1'b0, 2, 6);
    chk("d645",   32'(vga1), 32'(mem_word(18'd645)));
    chk("pv645",  32'(pv1), 32'd1);

    // 2x scale latched at frame boundary: (3,7) and (3,6) -> 323
    frame(1'b1, 0, 0);
    mode = 1'b0;                       // mid-frame change must not matter
    cyc(1'b0, 3, 7);
    chk("a323_c7", 32'(vif1.vram_addr), 32'd323);
    cyc(1'b0, 3, 6);
    chk("a323_c6", 32'(vif1.vram_addr), 32'd323);

    // Wrap in both axes: (0,1) with scroll 319/239 -> 76480
    frame(1'b0, 319, 239);
    cyc(1'b0, 0, 1);
    chk("a76480", 32'(vif1.vram_addr), 32'd76480);

    // Border and blank
    border_color = 12'hF00;
    cyc(1'b0, 10, 400);
    chk("brd_rden", 32'(vif1.vram_rd_en), 32'd0);
    cyc(1'b0, 10, 700);
    chk("brd_data", 32'({pv1, vga1}), 32'h1F00);
    cyc(1'b0, 10, 701);
    chk("blank_out", 32'({pv1, vga1}), 32'h0);

    // Full-line sweep (latency-3 alignment at col 0 and 639 included)
    frame(1'b0, 0, 0);
    for (int i = 0; i < 640; i++) cyc(1'b0, 50, i);
    for (int i = 0; i < 4; i++) cyc(1'b0, 50, 640 + i);

    // Scroll change mid-frame takes effect only at the next boundary
    cyc(1'b0, 100, 10);
    scroll_x = 10'd5;
    cyc(1'b0, 100, 11);
    chk("scr_hold", 32'(vif1.vram_addr), 32'd32011);
    frame(1'b0, 5, 0);
    cyc(1'b0, 100, 11);
    chk("scr_new", 32'(vif1.vram_addr), 32'd32016);

    // Reset mid-line; shadows return to 0
    mode = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 5, 100 + i);
    cyc(1'b1, 5, 104);
    chk("mrst_addr", 32'(vif3.vram_addr), 32'd0);
    chk("mrst_out",  32'({pv3, vga3}), 32'd0);
    cyc(1'b0, 5, 105);
    chk("mrst_pv1", 32'(pv1), 32'd0);
    chk("mrst_shadow", 32'(vif1.vram_addr), 32'd1705);
    cyc(1'b0, 5, 106);
    chk("mrst_pv1b", 32'(pv1), 32'd1);

    // Randomized traffic: arbitrary jumps, boundaries, mid-frame control changes
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mode         = 1'($urandom_range(0, 1));
        scroll_x     = 10'($urandom_range(0, 319));
        scroll_y     = 9'($urandom_range(0, 239));
        border_color = 12'($urandom);
      end
      if ($urandom_range(0, 59) == 0) begin
        r = 480; c = 0;
      end else begin
        r = $urandom_range(0, 511);
        c = $urandom_range(0, 799);
      end
      cyc(($urandom_range(0, 249) == 0), r, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
Parametrised VRAM-to-VGA pixel fetcher, successor to the fixed 640x480 fetcher. Converts the VGA timing position (row, col) into framebuffer read addresses and delivers colour data aligned to the request. Supports a configurable read latency, 1x/2x pixel scaling, wrap-around X/Y scroll, and a border colour. Sits between the VGA timing generator and the display output register.

Parameters:
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
FB_W, 320, framebuffer width in pixels
FB_H, 240, framebuffer height in pixels
ROW_W, 9, row input width
COL_W, 10, col input width
ADDR_W, 18, VRAM address width
DATA_W, 12, pixel width (RGB444)
RD_LAT, 1, VRAM read latency in clocks (>=1)
BASE_ADDR, 0, framebuffer start address

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
row  in  ROW_W  current timing row
col  in  COL_W  current timing column
mode  in  1  0 = 1x, 1 = 2x scale
scroll_x  in  COL_W  X scroll, must be < FB_W
scroll_y  in  ROW_W  Y scroll, must be < FB_H
border_color  in  DATA_W  colour for visible pixels outside the framebuffer
vram_addr  out  ADDR_W  registered read address
vram_rd_en  out  1  read strobe for the addressed pixel
vram_data  in  DATA_W  read data, valid RD_LAT clocks after the address
vga_data  out  DATA_W  registered output pixel
pix_valid  out  1  high when vga_data is a visible pixel

Behaviour:
- One clock (clk); rst is synchronous, active-high. All outputs are registered.
- Reset values: vram_addr=0, vram_rd_en=0, vga_data=0, pix_valid=0, shadow mode=0, shadow scroll_x/scroll_y=0, all pipeline flags cleared.
- Shadow registers: mode, scroll_x and scroll_y are sampled only on the clock where row==V_ACTIVE and col==0, which is the first blanking line. Changes elsewhere have no effect until the next frame boundary.
- Classification of the (row, col) sampled at edge E0:
  - blank: col>=H_ACTIVE or row>=V_ACTIVE.
  - border: visible, and (col>>s)>=FB_W or (row>>s)>=FB_H, where s = shadow mode.
  - fetch: otherwise.
- Address: fx = ((col>>s)+scroll_x) mod FB_W; fy = ((row>>s)+scroll_y) mod FB_H; vram_addr = BASE_ADDR + fy*FB_W + fx, truncated to ADDR_W.
  - Wrap is a single conditional subtract; the sum is always < 2*FB_W (resp. 2*FB_H).
- Fetch at E0: vram_addr and vram_rd_en=1 are registered at E0.
- Border or blank at E0: vram_rd_en=0 and vram_addr holds its previous value.
- Alignment: a RD_LAT-deep shift register carries the class (fetch/border/blank) for each sample. At edge E0+RD_LAT:
  - fetch: vga_data = vram_data, pix_valid=1.
  - border: vga_data = border_color (sampled at E0), pix_valid=1.
  - blank: vga_data = 0, pix_valid=0.
- Latency is exactly RD_LAT clocks from the (row, col) sample to vga_data. It is independent of mode, scroll and class.
- row/col may jump arbitrarily, e.g. a timing restart. No internal state depends on sequential col values except the pipeline, so the output stays correct RD_LAT clocks later.
- Reset mid-line clears the pipeline. vga_data=0 and pix_valid=0 until RD_LAT clocks after the first post-reset sample. Shadow registers stay at 0 until the next frame boundary.
- rst and a frame boundary in the same cycle: rst wins.

Test Plan:
- Reset, RD_LAT=1, mode=0, scroll=0. Drive row=2, col=5 → vram_addr=645 and rd_en=1 after 1 clk; vga_data equals the memory word at 645 one clk later; pix_valid=1.
- mode=1 latched at the frame boundary. Drive row=3, col=7 → fx=3, fy=1, vram_addr=323. col=6 gives the same address (pixel doubling).
- mode=0, latched scroll_x=319, scroll_y=239. Drive row=0, col=1 → fx=0, fy=239, vram_addr=76480 (wrap-around in both axes).
- mode=0, border_color=12'hF00. Drive row=10, col=400 → rd_en=0, vga_data=12'hF00, pix_valid=1. Drive col=700 → vga_data=0, pix_valid=0.
- RD_LAT=3 with a memory model. Sweep col 0..639 on one row → each vga_data matches its address exactly 3 clocks after the sample; no off-by-one at col 0 or 639.
- Change scroll_x mid-frame (row=100) → addresses unchanged until row=480/col=0, then updated. Assert rst mid-line → all outputs 0 the next clock.
